usb_rc_dpdm: RTL and testbench
==============================

USB_RC_DPDM -- requirements
Module: usb_rc_dpdm

Interface
REQ-001 The module SHALL expose these ports, clock and reset first:
- clk  in  1  system clock, one bus symbol sampled per rising edge.
- rst_n  in  1  reset, synchronous and active-high, despite the codebase "_n" port name.
- bus_in  in  2  D+/D- line symbol: J=2'b10, K=2'b01, SE0=2'b00, SE1=2'b11.
- enable  in  1  1 = local transmitter owns the bus; the receiver ignores bus_in.
- receive_hshake  in  1  expect a handshake packet of exactly 8 raw bits.
- receive_data  in  1  expect a data packet of any length terminated by EOP.
- abort  in  1  abandon reception.
- s_out  out  1  registered line level, J=1, K=0, for the downstream NRZI decoder.
- start_rc_nrzi  out  1  one-cycle pulse, starts the NRZI decoder.
- end_rc_nrzi  out  1  one-cycle pulse, stops the NRZI decoder.
- got_sync  out  1  one-cycle pulse on SYNC match.
- EOP_error  out  1  one-cycle pulse on a malformed packet end.

Function
REQ-002 The FSM SHALL have four states: IDLE, HUNT, RECEIVE, EOP.
REQ-003 IDLE→HUNT SHALL occur when (receive_hshake|receive_data)=1 and enable=0.
REQ-004 HUNT SHALL keep a history of the last 8 sampled symbols and match SYNC = K,J,K,J,K,J,K,K, oldest first.
REQ-005 On a match with the last K sampled at edge n, got_sync and start_rc_nrzi SHALL pulse high during cycle n+1, and the FSM SHALL enter RECEIVE.
REQ-006 s_out SHALL equal the level of the symbol sampled on the previous edge, so it is 0 (the final SYNC K) in the start_rc_nrzi cycle; this value is the NRZI reference.
REQ-007 In RECEIVE, every J/K sample SHALL appear on s_out one cycle later, and an internal raw-bit counter (saturating at 255) SHALL increment.
REQ-008 The first SE0 sampled in RECEIVE SHALL pulse end_rc_nrzi in the next cycle and move the FSM to EOP; s_out SHALL then hold its last value.
REQ-009 In EOP, SE0 followed by J SHALL return the FSM to IDLE; any other sequence SHALL pulse EOP_error and return to IDLE.
REQ-010 With receive_hshake=1, an EOP after a bit count other than 8 SHALL pulse EOP_error; the pulse coincides with end_rc_nrzi.
REQ-011 abort=1, or enable=1, in any state SHALL force IDLE on the next edge without pulsing any output.
REQ-012 When abort occurs in the same cycle as a SYNC match, abort SHALL win.
REQ-013 Pulses SHALL never last longer than one cycle, and no two of start/end pulses SHALL coincide.

Reset
REQ-014 Reset SHALL put the FSM in IDLE, clear the history and counter, and drive s_out=1 (idle J) with all pulse outputs low.
REQ-015 Reset asserted mid-packet SHALL take effect at the next edge and override abort and all other inputs.

Configuration
REQ-016 With RC_DPDM_SE1_CHECK_EN defined, an SE1 sampled in RECEIVE or EOP SHALL pulse EOP_error and force IDLE.
REQ-017 Without RC_DPDM_SE1_CHECK_EN, SE1 SHALL be treated as a repeat of the previous J/K level.

Structure
REQ-018 A shared package SHALL hold the J/K/SE0/SE1 constants, the state enum and the 16-bit SYNC pattern.
REQ-019 SYNC matching SHALL live in one sub-module, rc_sync_detect, with inputs clk, rst_n, clear and bus_in and output match.

Verification
REQ-020 The bench SHALL cover these scenarios:
- receive_hshake=1, bus KJKJKJKK → got_sync=1 and start_rc_nrzi=1 for one cycle, s_out=0.
- Same SYNC, then JJKJJKKK, SE0, SE0, J → s_out follows 1,1,0,1,1,0,0,0; end_rc_nrzi pulses once; FSM returns to IDLE; EOP_error=0.
- Handshake with 7 bits then EOP → EOP_error=1 coincident with end_rc_nrzi.
- EOP as SE0 then K → EOP_error=1, FSM in IDLE.
- abort=1 mid-RECEIVE → IDLE next cycle, no end_rc_nrzi pulse.
- SE1 mid-packet → EOP_error=1 when RC_DPDM_SE1_CHECK_EN is defined; without it, no error and s_out is unchanged.

Source files
------------

// File: rtl/usb_rc_dpdm_pkg.sv
// Shared line-symbol constants, receiver state encoding and SYNC pattern for usb_rc_dpdm.
package usb_rc_dpdm_pkg;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam logic [1:0] SYM_SE1 = 2'b11;

    // K,J,K,J,K,J,K,K with the oldest symbol in the MSBs
    localparam logic [15:0] SYNC_PAT = {SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_RECEIVE = 2'd2,
        ST_EOP     = 2'd3
    } rc_state_e;
endpackage

// File: rtl/rc_sync_detect.sv
// SYNC matcher: seven registered symbols plus the live one form the 8-symbol window,
// so match is valid in the cycle whose edge samples the final K.
module rc_sync_detect
    import usb_rc_dpdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [1:0] bus_in,
    output logic       match
);
    logic [13:0] r_hist;

    // A cleared history is all SE0, which can never alias the SYNC pattern
    always_ff @(posedge clk) begin
        if (rst_n || clear) r_hist <= '0;
        else                r_hist <= {r_hist[11:0], bus_in};
    end

    assign match = !clear && ({r_hist, bus_in} == SYNC_PAT);
endmodule

// File: rtl/usb_rc_dpdm.sv
// D+/D- receive front end: hunts for SYNC, forwards J/K levels to the NRZI decoder, checks EOP.
// Define RC_DPDM_SE1_CHECK_EN to flag SE1 during a packet as an error instead of a repeated level.
module usb_rc_dpdm
    import usb_rc_dpdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] bus_in,
    input  logic       enable,
    input  logic       receive_hshake,
    input  logic       receive_data,
    input  logic       abort,
    output logic       s_out,
    output logic       start_rc_nrzi,
    output logic       end_rc_nrzi,
    output logic       got_sync,
    output logic       EOP_error
);
    rc_state_e  r_state;
    logic [7:0] r_cnt;
    logic       r_eop_se0;
    logic       r_s_out;
    logic       r_start;
    logic       r_end;
    logic       r_sync;
    logic       r_err;
    logic       w_clear;
    logic       w_match;
    logic       w_se1_fault;
    logic [1:0] w_sym;

    assign w_clear = (r_state != ST_HUNT) || abort || enable;

    rc_sync_detect u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_clear),
        .bus_in (bus_in),
        .match  (w_match)
    );

`ifdef RC_DPDM_SE1_CHECK_EN
    assign w_se1_fault = (bus_in == SYM_SE1);
    assign w_sym       = bus_in;
`else
    assign w_se1_fault = 1'b0;
    assign w_sym       = (bus_in == SYM_SE1) ? (r_s_out ? SYM_J : SYM_K) : bus_in;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_eop_se0 <= 1'b0;
            r_s_out   <= 1'b1;
            r_start   <= 1'b0;
            r_end     <= 1'b0;
            r_sync    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_end   <= 1'b0;
            r_sync  <= 1'b0;
            r_err   <= 1'b0;
            if (abort || enable) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (receive_hshake || receive_data) r_state <= ST_HUNT;
                    end
                    ST_HUNT: begin
                        if (bus_in == SYM_J || bus_in == SYM_K) r_s_out <= (bus_in == SYM_J);
                        if (w_match) begin
                            r_sync  <= 1'b1;
                            r_start <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_RECEIVE;
                        end
                    end
                    ST_RECEIVE: begin
                        if (w_se1_fault) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_sym == SYM_SE0) begin
                            // A handshake is exactly 8 raw bits; anything else is a bad end
                            r_end     <= 1'b1;
                            r_err     <= receive_hshake && (r_cnt != 8'd8);
                            r_eop_se0 <= 1'b0;
                            r_state   <= ST_EOP;
                        end else begin
                            r_s_out <= (w_sym == SYM_J);
                            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    ST_EOP: begin
                        if (w_se1_fault) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (!r_eop_se0) begin
                            if (w_sym == SYM_SE0) begin
                                r_eop_se0 <= 1'b1;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            if (w_sym != SYM_J) r_err <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_out         = r_s_out;
    assign start_rc_nrzi = r_start;
    assign end_rc_nrzi   = r_end;
    assign got_sync      = r_sync;
    assign EOP_error     = r_err;
endmodule

// File: tb/tb_usb_rc_dpdm.sv
// Directed-vector bench for usb_rc_dpdm: table of per-edge stimulus/expectations plus hand sequences.
module tb_usb_rc_dpdm;
    localparam logic [1:0] J = 2'b10, K = 2'b01, S0 = 2'b00, S1 = 2'b11;
    localparam logic [1:0] I = 2'd0, H = 2'd1, R = 2'd2, E = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] bus_in = J;
    logic       enable = 1'b0, receive_hshake = 1'b0, receive_data = 1'b0, abort = 1'b0;
    logic       s_out, start_rc_nrzi, end_rc_nrzi, got_sync, EOP_error;

    int nvec = 0;
    int nmis = 0;

    usb_rc_dpdm dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus_in         (bus_in),
        .enable         (enable),
        .receive_hshake (receive_hshake),
        .receive_data   (receive_data),
        .abort          (abort),
        .s_out          (s_out),
        .start_rc_nrzi  (start_rc_nrzi),
        .end_rc_nrzi    (end_rc_nrzi),
        .got_sync       (got_sync),
        .EOP_error      (EOP_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, hs, dat, ab;
        logic [1:0] bus;
        logic [6:0] exp;  // {s_out, start, end, sync, err, state[1:0]}
    } vec_t;

    vec_t tbl[$];

    task automatic V(input logic rst, input logic [1:0] bus, input logic en, input logic hs,
                     input logic dat, input logic ab, input logic s, input logic st,
                     input logic ed, input logic sy, input logic er, input logic [1:0] state);
        vec_t v;
        v.rst = rst; v.bus = bus; v.en = en; v.hs = hs; v.dat = dat; v.ab = ab;
        v.exp = {s, st, ed, sy, er, state};
        tbl.push_back(v);
    endtask

    // Seven SYNC symbols that leave the receiver still hunting
    task automatic add_sync7(input logic hs, input logic dat);
        V(0, K, 0, hs, dat, 0, 0, 0, 0, 0, 0, H);
        V(0, J, 0, hs, dat, 0, 1, 0, 0, 0, 0, H);
        V(0, K, 0, hs, dat, 0, 0, 0, 0, 0, 0, H);
        V(0, J, 0, hs, dat, 0, 1, 0, 0, 0, 0, H);
        V(0, K, 0, hs, dat, 0, 0, 0, 0, 0, 0, H);
        V(0, J, 0, hs, dat, 0, 1, 0, 0, 0, 0, H);
        V(0, K, 0, hs, dat, 0, 0, 0, 0, 0, 0, H);
    endtask

    task automatic add_sync(input logic hs, input logic dat);
        add_sync7(hs, dat);
        V(0, K, 0, hs, dat, 0, 0, 1, 0, 1, 0, R);
    endtask

    task automatic chk(input string name, input logic [6:0] exp);
        logic [1:0] st;
        logic [6:0] act;
        st  = dut.r_state;
        act = {s_out, start_rc_nrzi, end_rc_nrzi, got_sync, EOP_error, st};
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got {s,st,end,sync,err,state}=%b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] bus, input logic en,
                         input logic hs, input logic dat, input logic ab);
        rst_n = rst; bus_in = bus; enable = en;
        receive_hshake = hs; receive_data = dat; abort = ab;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, then 8-bit handshake JJKJJKKK with a clean SE0,SE0,J end
        V(1, J, 0, 0, 0, 0, 1, 0, 0, 0, 0, I);
        V(0, J, 0, 1, 0, 0, 1, 0, 0, 0, 0, H);
        add_sync(1, 0);
        V(0, J, 0, 1, 0, 0, 1, 0, 0, 0, 0, R);
        V(0, J, 0, 1, 0, 0, 1, 0, 0, 0, 0, R);
        V(0, K, 0, 1, 0, 0, 0, 0, 0, 0, 0, R);
        V(0, J, 0, 1, 0, 0, 1, 0, 0, 0, 0, R);
        V(0, J, 0, 1, 0, 0, 1, 0, 0, 0, 0, R);
        V(0, K, 0, 1, 0, 0, 0, 0, 0, 0, 0, R);
        V(0, K, 0, 1, 0, 0, 0, 0, 0, 0, 0, R);
        V(0, K, 0, 1, 0, 0, 0, 0, 0, 0, 0, R);
        V(0, S0, 0, 1, 0, 0, 0, 0, 1, 0, 0, E);
        V(0, S0, 0, 1, 0, 0, 0, 0, 0, 0, 0, E);
        V(0, J, 0, 1, 0, 0, 0, 0, 0, 0, 0, I);
        V(0, J, 0, 0, 0, 0, 0, 0, 0, 0, 0, I);
        // handshake with 7 bits: error rides on end pulse
        V(0, J, 0, 1, 0, 0, 0, 0, 0, 0, 0, H);
        add_sync(1, 0);
        V(0, J, 0, 1, 0, 0, 1, 0, 0, 0, 0, R);
        V(0, J, 0, 1, 0, 0, 1, 0, 0, 0, 0, R);
        V(0, K, 0, 1, 0, 0, 0, 0, 0, 0, 0, R);
        V(0, J, 0, 1, 0, 0, 1, 0, 0, 0, 0, R);
        V(0, J, 0, 1, 0, 0, 1, 0, 0, 0, 0, R);
        V(0, K, 0, 1, 0, 0, 0, 0, 0, 0, 0, R);
        V(0, K, 0, 1, 0, 0, 0, 0, 0, 0, 0, R);
        V(0, S0, 0, 1, 0, 0, 0, 0, 1, 0, 1, E);
        V(0, S0, 0, 1, 0, 0, 0, 0, 0, 0, 0, E);
        V(0, J, 0, 1, 0, 0, 0, 0, 0, 0, 0, I);
        // data packet ending SE0 then K
        V(0, J, 0, 0, 1, 0, 0, 0, 0, 0, 0, H);
        add_sync(0, 1);
        V(0, J, 0, 0, 1, 0, 1, 0, 0, 0, 0, R);
        V(0, K, 0, 0, 1, 0, 0, 0, 0, 0, 0, R);
        V(0, S0, 0, 0, 1, 0, 0, 0, 1, 0, 0, E);
        V(0, K, 0, 0, 1, 0, 0, 0, 0, 0, 1, I);
        // abort mid-receive
        V(0, J, 0, 0, 1, 0, 0, 0, 0, 0, 0, H);
        add_sync(0, 1);
        V(0, J, 0, 0, 1, 0, 1, 0, 0, 0, 0, R);
        V(0, K, 0, 0, 1, 0, 0, 0, 0, 0, 0, R);
        V(0, S0, 0, 0, 1, 1, 0, 0, 0, 0, 0, I);
        V(0, S0, 0, 0, 0, 0, 0, 0, 0, 0, 0, I);
        // SE1 in the middle of a data packet
        V(0, J, 0, 0, 1, 0, 0, 0, 0, 0, 0, H);
        add_sync(0, 1);
        V(0, J, 0, 0, 1, 0, 1, 0, 0, 0, 0, R);
`ifdef RC_DPDM_SE1_CHECK_EN
        V(0, S1, 0, 0, 1, 0, 1, 0, 0, 0, 1, I);
        V(0, J, 0, 0, 0, 0, 1, 0, 0, 0, 0, I);
`else
        V(0, S1, 0, 0, 1, 0, 1, 0, 0, 0, 0, R);
        V(0, S0, 0, 0, 1, 0, 1, 0, 1, 0, 0, E);
        V(0, S0, 0, 0, 1, 0, 1, 0, 0, 0, 0, E);
        V(0, J, 0, 0, 1, 0, 1, 0, 0, 0, 0, I);
`endif
        // enable forces idle and blocks hunting
        V(0, J, 0, 0, 1, 0, 1, 0, 0, 0, 0, H);
        V(0, K, 1, 0, 1, 0, 1, 0, 0, 0, 0, I);
        V(0, K, 1, 1, 1, 0, 1, 0, 0, 0, 0, I);
        // reset mid-packet overrides abort and restores idle J
        V(0, J, 0, 0, 1, 0, 1, 0, 0, 0, 0, H);
        add_sync(0, 1);
        V(0, J, 0, 0, 1, 0, 1, 0, 0, 0, 0, R);
        V(0, K, 0, 0, 1, 0, 0, 0, 0, 0, 0, R);
        V(1, K, 0, 0, 1, 1, 1, 0, 0, 0, 0, I);
        V(0, S0, 0, 0, 0, 0, 1, 0, 0, 0, 0, I);

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].rst, tbl[n].bus, tbl[n].en, tbl[n].hs, tbl[n].dat, tbl[n].ab);
            chk($sformatf("vec%0d", n), tbl[n].exp);
        end

        // abort on the very edge that completes SYNC: no pulse, back to idle
        tbl.delete();
        V(0, J, 0, 0, 1, 0, 1, 0, 0, 0, 0, H);
        add_sync7(0, 1);
        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].rst, tbl[n].bus, tbl[n].en, tbl[n].hs, tbl[n].dat, tbl[n].ab);
            chk($sformatf("abm_pre%0d", n), tbl[n].exp);
        end
        drive(0, K, 0, 0, 1, 1);
        chk("abort_on_match", {1'b0, 4'b0000, I});
        drive(0, J, 0, 0, 0, 0);
        chk("abort_on_match_after", {1'b0, 4'b0000, I});

        // 9-bit random handshake: s_out tracks each bit, wrong length flagged at EOP
        begin
            logic [1:0] sym;
            tbl.delete();
            V(0, J, 0, 1, 0, 0, 0, 0, 0, 0, 0, H);
            add_sync(1, 0);
            for (int n = 0; n < tbl.size(); n++) begin
                drive(tbl[n].rst, tbl[n].bus, tbl[n].en, tbl[n].hs, tbl[n].dat, tbl[n].ab);
                chk($sformatf("rnd_sync%0d", n), tbl[n].exp);
            end
            for (int b = 0; b < 9; b++) begin
                sym = ($urandom_range(0, 1) == 1) ? J : K;
                drive(0, sym, 0, 1, 0, 0);
                chk($sformatf("rnd_bit%0d", b), {(sym == J), 4'b0000, R});
            end
            drive(0, S0, 0, 1, 0, 0);
            chk("rnd_eop", {(sym == J), 4'b0101, E});
            drive(0, S0, 0, 1, 0, 0);
            chk("rnd_eop2", {(sym == J), 4'b0000, E});
            drive(0, J, 0, 0, 0, 0);
            chk("rnd_idle", {(sym == J), 4'b0000, I});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
